key_matrix_scan: RTL and testbench

- Scans a ROWS x COLS passive key matrix by driving one row low at a time and sampling the columns.
- Debounces every key with its own counter.
- Reports press and release events one at a time over a valid/ready handshake, and exposes the full debounced key map.
- Sits between the board-level key matrix pins and the user-interface logic, replacing one debounce instance per key with a single scheduled controller.

---
 rtl/key_matrix_scan.sv | 168 ++++++++++++++++
 tb/tb_key_matrix_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - scanned key matrix with per-key debounce and press/release event port
module key_matrix_scan #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int SYNC_STAGES    = 2,
   localparam int NKEYS         = ROWS * COLS,
   localparam int KW            = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [ROWS-1:0]  row_n,
   input  logic [COLS-1:0]  col_n,
   output logic [NKEYS-1:0] key_state,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [KW-1:0]    evt_key,
   output logic             evt_press
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW = $clog2(SCAN_DIV);
   localparam int NW = $clog2(DEBOUNCE_SCANS) + 1;

   typedef enum logic [1:0] {SETTLE, CHECK, ADVANCE} state_t;

   state_t state, state_next;

   (* ASYNC_REG = "TRUE" *) logic [COLS-1:0] sync [SYNC_STAGES];

   logic [COLS-1:0] pressed_cols;
   logic [COLS-1:0] snap;
   logic [DW-1:0]   div;
   logic [RW-1:0]   row_idx;
   logic [CW-1:0]   col_idx;
   logic [NW-1:0]   cnt [NKEYS];

   logic [KW-1:0]   key_idx;
   logic            s;
   logic            cur;
   logic [NW-1:0]   cnt_k;
   logic            differ;
   logic            at_max;
   logic            slot_free;
   logic            stall;

   logic            capture;
   logic            check_en;
   logic            do_flip;
   logic            last_col;
   logic            row_step;

   // Column synchronizer; idles at "not pressed" so reset never looks like a key.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '1;
      end else begin
         sync[0] <= col_n;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      end
   end

   assign pressed_cols = ~sync[SYNC_STAGES-1];

   // Decode of the key currently under inspection and whether its flip must wait.
   always_comb begin
      key_idx   = KW'(row_idx * COLS + col_idx);
      s         = snap[col_idx];
      cur       = key_state[key_idx];
      cnt_k     = cnt[key_idx];
      differ    = (s != cur);
      at_max    = (cnt_k == NW'(DEBOUNCE_SCANS - 1));
      slot_free = !evt_valid || evt_ready;
      stall     = (state == CHECK) && differ && at_max && !slot_free;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= SETTLE;
      else        state <= state_next;
   end

   // Next-state logic: settle a row, walk its columns, then step to the next row.
   always_comb begin
      state_next = state;
      case (state)
         SETTLE:  if (div == DW'(SCAN_DIV - 1)) state_next = CHECK;
         CHECK:   if (!stall && (col_idx == CW'(COLS - 1))) state_next = ADVANCE;
         ADVANCE: state_next = SETTLE;
         default: state_next = SETTLE;
      endcase
   end

   // Control strobes derived from the current state.
   always_comb begin
      capture  = (state == SETTLE) && (div == DW'(SCAN_DIV - 1));
      check_en = (state == CHECK) && !stall;
      do_flip  = check_en && differ && at_max;
      last_col = (col_idx == CW'(COLS - 1));
      row_step = (state == ADVANCE);
   end

   // Scan sequencing: settle divider, column snapshot, column and row indices.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div     <= '0;
         snap    <= '0;
         col_idx <= '0;
         row_idx <= '0;
      end else begin
         if (row_step)
            div <= '0;
         else if ((state == SETTLE) && !capture)
            div <= div + 1'b1;
         if (capture) begin
            snap    <= pressed_cols;
            col_idx <= '0;
         end else if (check_en && !last_col) begin
            col_idx <= col_idx + 1'b1;
         end
         if (row_step)
            row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      end
   end

   // Per-key debounce: count consecutive disagreeing samples, flip on the last one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_state <= '0;
         for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
      end else if (check_en) begin
         if (!differ) begin
            cnt[key_idx] <= '0;
         end else if (!at_max) begin
            cnt[key_idx] <= cnt_k + 1'b1;
         end else begin
            key_state[key_idx] <= s;
            cnt[key_idx]       <= '0;
         end
      end
   end

   // Single-entry event slot; a new flip may refill it in the cycle it drains.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_key   <= '0;
         evt_press <= 1'b0;
      end else begin
         if (evt_valid && evt_ready)
            evt_valid <= 1'b0;
         if (do_flip) begin
            evt_valid <= 1'b1;
            evt_key   <= key_idx;
            evt_press <= s;
         end
      end
   end

   // Row drive follows the row index one cycle behind; released while in reset.
   always_ff @(posedge clk) begin
      if (!rst_n) row_n <= '1;
      else        row_n <= ~(ROWS'(1) << row_idx);
   end

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb/tb_key_matrix_scan.sv - directed bench for key_matrix_scan on a 2x2 matrix
module tb_key_matrix_scan;

   logic       clk;
   logic       rst_n;
   logic [1:0] row_n;
   logic [1:0] col_n;
   logic [3:0] key_state;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_key;
   logic       evt_press;

   logic [3:0] pressed;
   logic       force_low;
   logic [1:0] col_model;

   int checks;
   int errors;
   int ev_count;
   int base;

   key_matrix_scan #(
      .ROWS(2), .COLS(2), .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
      .key_state(key_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_key(evt_key), .evt_press(evt_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col_model = 2'b11;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            if (pressed[r*2+c] && !row_n[r]) col_model[c] = 1'b0;
   end
   assign col_n = force_low ? 2'b00 : col_model;

   // Count completed handshakes.
   initial ev_count = 0;
   always @(posedge clk) begin
      if (evt_valid && evt_ready) ev_count <= ev_count + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      force_low = 1'b1;
      evt_ready = 1'b1;
      pressed   = 4'b0000;
      tick(5);
      check("rst_row_n", 32'(row_n), 32'h3);
      check("rst_key_state", 32'(key_state), 32'h0);
      check("rst_evt_valid", 32'(evt_valid), 32'h0);
      check("rst_evt_key", 32'(evt_key), 32'h0);
      check("rst_evt_press", 32'(evt_press), 32'h0);

      rst_n     = 1'b1;
      force_low = 1'b0;
      tick(1);
      check("row0_first", 32'(row_n), 32'h2);
      tick(6);
      check("row0_hold", 32'(row_n), 32'h2);
      tick(1);
      check("row1_after7", 32'(row_n), 32'h1);

      // Press key 3 and hold it.
      base    = ev_count;
      pressed = 4'b1000;
      tick(32);
      check("press3_early", 32'(evt_valid), 32'h0);
      tick(1);
      check("press3_valid", 32'(evt_valid), 32'h1);
      check("press3_key", 32'(evt_key), 32'h3);
      check("press3_press", 32'(evt_press), 32'h1);
      check("press3_state", 32'(key_state), 32'h8);
      tick(42);
      check("press3_once", 32'(ev_count - base), 32'h1);
      check("press3_idle", 32'(evt_valid), 32'h0);
      check("press3_held", 32'(key_state), 32'h8);

      // Release key 3.
      pressed = 4'b0000;
      tick(41);
      check("rel3_early", 32'(evt_valid), 32'h0);
      check("rel3_early_state", 32'(key_state), 32'h8);
      tick(1);
      check("rel3_valid", 32'(evt_valid), 32'h1);
      check("rel3_key", 32'(evt_key), 32'h3);
      check("rel3_press", 32'(evt_press), 32'h0);
      check("rel3_state", 32'(key_state), 32'h0);
      tick(1);
      check("rel3_count", 32'(ev_count - base), 32'h2);
      check("rel3_idle", 32'(evt_valid), 32'h0);

      // Glitch on key 0 lasting two scans.
      pressed = 4'b0001;
      tick(19);
      check("glitch_cnt2", 32'(dut.cnt[0]), 32'h2);
      check("glitch_novalid", 32'(evt_valid), 32'h0);
      tick(9);
      pressed = 4'b0000;
      tick(6);
      check("glitch_cnt0", 32'(dut.cnt[0]), 32'h0);
      check("glitch_state", 32'(key_state), 32'h0);
      check("glitch_noevt", 32'(ev_count - base), 32'h2);

      // Keys 0 and 1 flip in the same scan with the consumer stalled.
      evt_ready = 1'b0;
      pressed   = 4'b0011;
      tick(41);
      check("bp_valid", 32'(evt_valid), 32'h1);
      check("bp_key", 32'(evt_key), 32'h0);
      check("bp_press", 32'(evt_press), 32'h1);
      check("bp_state", 32'(key_state), 32'h1);
      tick(9);
      check("bp_row_frozen", 32'(row_n), 32'h2);
      check("bp_key_held", 32'(evt_key), 32'h0);
      check("bp_state_held", 32'(key_state), 32'h1);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("bp_next_valid", 32'(evt_valid), 32'h1);
      check("bp_next_key", 32'(evt_key), 32'h1);
      check("bp_next_press", 32'(evt_press), 32'h1);
      check("bp_next_state", 32'(key_state), 32'h3);
      check("bp_count", 32'(ev_count - base), 32'h3);
      tick(2);
      check("bp_resumed", 32'(row_n), 32'h1);

      // Release both keys so key 0 stalls behind the pending event, then reset.
      pressed = 4'b0000;
      tick(42);
      check("st2_valid", 32'(evt_valid), 32'h1);
      check("st2_key", 32'(evt_key), 32'h1);
      check("st2_row", 32'(row_n), 32'h2);
      check("st2_state", 32'(key_state), 32'h3);
      check("st2_cnt", 32'(dut.cnt[0]), 32'h2);
      rst_n = 1'b0;
      tick(1);
      check("mrst_valid", 32'(evt_valid), 32'h0);
      check("mrst_state", 32'(key_state), 32'h0);
      check("mrst_row", 32'(row_n), 32'h3);
      check("mrst_key", 32'(evt_key), 32'h0);
      check("mrst_cnt", 32'(dut.cnt[0]), 32'h0);
      rst_n = 1'b1;
      tick(1);
      check("mrst_restart", 32'(row_n), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
